// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   DEFAULT_GROUP : default bits per lookahead group
//   MAX_GROUP     : widest group slice group_gp() accepts
//   group_gp()    : {G, P} of an n-bit generate/propagate slice
//   num_groups()  : number of lookahead groups for a given width
//   width_ok()    : legality check of a WIDTH/GROUP pair
package cla_pkg;

  localparam int unsigned DEFAULT_GROUP = 8;
  localparam int unsigned MAX_GROUP     = 64;

  // G = g[n-1] | p[n-1]g[n-2] | ... | p[n-1..1]g[0]; P = &p[n-1:0].
  // Written as a fold; synthesis flattens it into the two-level form.
  function automatic logic [1:0] group_gp(input logic [MAX_GROUP-1:0] g,
                                          input logic [MAX_GROUP-1:0] p,
                                          input int unsigned          n);
    logic gg;
    logic pp;
    gg = 1'b0;
    pp = 1'b1;
    for (int unsigned i = 0; i < MAX_GROUP; i++) begin
      if (i < n) begin
        gg = g[i] | (p[i] & gg);
        pp = pp & p[i];
      end
    end
    return {gg, pp};
  endfunction

  function automatic int unsigned num_groups(input int unsigned width,
                                             input int unsigned group);
    return width / group;
  endfunction

  function automatic bit width_ok(input int unsigned width,
                                  input int unsigned group);
    return (group != 0) && (group <= MAX_GROUP) && (width != 0) &&
           ((width % group) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit lookahead cell.
//   a, b     : group operand slices (b already conditioned for subtract)
//   cin      : carry into the group's LSB
//   g_grp_c  : group generate
//   p_grp_c  : group propagate
//   sum_c    : group sum, every bit's carry formed by flat lookahead from cin
module cla_group
  import cla_pkg::*;
#(
  parameter int unsigned GROUP = DEFAULT_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic             g_grp_c,
  output logic             p_grp_c,
  output logic [GROUP-1:0] sum_c
);

  if (GROUP == 0 || GROUP > MAX_GROUP) begin : g_bad_group
    $fatal(1, "cla_group: GROUP out of range");
  end

  logic [GROUP-1:0] g_c;
  logic [GROUP-1:0] p_c;
  logic [GROUP-1:0] carry_c;
  logic [1:0]       gp_c;
  logic             term_c;
  logic             acc_c;

  assign g_c = a & b;
  assign p_c = a ^ b;

  assign gp_c    = group_gp(MAX_GROUP'(g_c), MAX_GROUP'(p_c), GROUP);
  assign g_grp_c = gp_c[1];
  assign p_grp_c = gp_c[0];

  // Carry into bit i: cin&p[0..i-1] | OR_j g[j]&p[j+1..i-1], no ripple.
  always_comb begin
    carry_c = '0;
    term_c  = 1'b0;
    acc_c   = 1'b0;
    for (int i = 0; i < int'(GROUP); i++) begin
      term_c = cin;
      for (int m = 0; m < i; m++) begin
        term_c = term_c & p_c[m];
      end
      acc_c = term_c;
      for (int j = 0; j < i; j++) begin
        term_c = g_c[j];
        for (int m = j + 1; m < i; m++) begin
          term_c = term_c & p_c[m];
        end
        acc_c = acc_c | term_c;
      end
      carry_c[i] = acc_c;
    end
  end

  assign sum_c = p_c ^ carry_c;

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready.
//   clock, reset_n        : rising-edge clock, async active-low reset
//   in_valid / in_ready   : operand handshake
//   a, b, sub, cin        : operands; sub=1 computes a-b and ignores cin
//   out_valid / out_ready : result handshake, result held until taken
//   sum, cout, ovf, zero  : result, MSB carry (no-borrow in sub), signed
//                           overflow, sum==0
// Stage 1 registers operands and per-group G/P; stage 2 forms the group
// carries by flat lookahead over the registered G/P and the group sums.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = DEFAULT_GROUP
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  if (!width_ok(WIDTH, GROUP)) begin : g_bad_width
    $fatal(1, "cla_pipe_adder: WIDTH must be a nonzero multiple of GROUP");
  end

  localparam int unsigned NG = num_groups(WIDTH, GROUP);

  // Operand conditioning and stage-1 group generate/propagate
  logic [WIDTH-1:0] bp_c;
  logic             c0_c;
  logic [NG-1:0]    gg_c;
  logic [NG-1:0]    gp_c;
  logic [WIDTH-1:0] unused_s1_sum;

  assign bp_c = sub ? ~b : b;
  assign c0_c = sub | cin;

  // Stage registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bp_q, bp_d;
  logic             c0_q, c0_d;
  logic [NG-1:0]    gg_q, gg_d;
  logic [NG-1:0]    gp_q, gp_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Stage-2 combinational results
  logic [NG:0]      gc_c;
  logic [WIDTH-1:0] sum_c;
  logic [NG-1:0]    unused_s2_g;
  logic [NG-1:0]    unused_s2_p;
  logic             grp_term_c;
  logic             grp_acc_c;

  logic             s1_adv_c;
  logic             in_ready_c;
  logic             in_xfer_c;

  for (genvar k = 0; k < int'(NG); k++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_s1 (
      .a       (a[k*GROUP +: GROUP]),
      .b       (bp_c[k*GROUP +: GROUP]),
      .cin     (1'b0),
      .g_grp_c (gg_c[k]),
      .p_grp_c (gp_c[k]),
      .sum_c   (unused_s1_sum[k*GROUP +: GROUP])
    );

    cla_group #(.GROUP(GROUP)) u_s2 (
      .a       (a_q[k*GROUP +: GROUP]),
      .b       (bp_q[k*GROUP +: GROUP]),
      .cin     (gc_c[k]),
      .g_grp_c (unused_s2_g[k]),
      .p_grp_c (unused_s2_p[k]),
      .sum_c   (sum_c[k*GROUP +: GROUP])
    );
  end

  // Group carries: C(k) = c0&P[0..k-1] | OR_j G[j]&P[j+1..k-1]
  always_comb begin
    gc_c       = '0;
    grp_term_c = 1'b0;
    grp_acc_c  = 1'b0;
    for (int k = 0; k <= int'(NG); k++) begin
      grp_term_c = c0_q;
      for (int m = 0; m < k; m++) begin
        grp_term_c = grp_term_c & gp_q[m];
      end
      grp_acc_c = grp_term_c;
      for (int j = 0; j < k; j++) begin
        grp_term_c = gg_q[j];
        for (int m = j + 1; m < k; m++) begin
          grp_term_c = grp_term_c & gp_q[m];
        end
        grp_acc_c = grp_acc_c | grp_term_c;
      end
      gc_c[k] = grp_acc_c;
    end
  end

  // Pipeline control and next-state
  always_comb begin
    s1_adv_c    = s1_valid_q && (!out_valid_q || out_ready);
    in_ready_c  = !s1_valid_q || s1_adv_c;
    in_xfer_c   = in_valid && in_ready_c;

    s1_valid_d  = in_xfer_c || (s1_valid_q && !s1_adv_c);
    a_d         = a_q;
    bp_d        = bp_q;
    c0_d        = c0_q;
    gg_d        = gg_q;
    gp_d        = gp_q;

    out_valid_d = s1_adv_c || (out_valid_q && !out_ready);
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;

    if (in_xfer_c) begin
      a_d  = a;
      bp_d = bp_c;
      c0_d = c0_c;
      gg_d = gg_c;
      gp_d = gp_c;
    end

    if (s1_adv_c) begin
      sum_d  = sum_c;
      cout_d = gc_c[NG];
      ovf_d  = (a_q[WIDTH-1] == bp_q[WIDTH-1]) &&
               (sum_c[WIDTH-1] != a_q[WIDTH-1]);
      zero_d = ~|sum_c;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      bp_q        <= '0;
      c0_q        <= 1'b0;
      gg_q        <= '0;
      gp_q        <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      bp_q        <= bp_d;
      c0_q        <= c0_d;
      gg_q        <= gg_d;
      gp_q        <= gp_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  // in_ready depends only on pipeline state and out_ready
  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=32, GROUP=8).
module tb_cla_pipe_adder;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  always #5 clock = ~clock;

  cla_pipe_adder #(.WIDTH(W), .GROUP(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  int   checks = 0;
  int   errors = 0;
  int   n_in   = 0;
  int   n_out  = 0;
  res_t q[$];
  res_t exp_r;
  res_t held;
  bit   stall_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
    end
  endtask

  // Reference: plain integer arithmetic on the mathematical operation
  function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic sv, input logic cv);
    res_t              r;
    longint unsigned   ua;
    longint unsigned   ub;
    longint unsigned   tot;
    longint            sa;
    longint            sb;
    longint            st;
    ua = 64'(av);
    ub = 64'(bv);
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (sv) begin
      tot    = ua - ub;
      r.cout = (ua >= ub);
      st     = sa - sb;
    end else begin
      tot    = ua + ub + 64'(cv);
      r.cout = (tot > 64'h0000_0000_FFFF_FFFF);
      st     = sa + sb + longint'(cv);
    end
    r.sum  = tot[W-1:0];
    r.ovf  = (st != longint'($signed(r.sum)));
    r.zero = (r.sum == '0);
    return r;
  endfunction

  // Per-cycle compare against the model queue, sampled mid-cycle
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_zero", 64'(zero), 64'd0);
      q.delete();
      stall_prev = 1'b0;
      n_in       = 0;
      n_out      = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_out_valid", 64'(out_valid), 64'd1);
        chk("hold_result", 64'({sum, cout, ovf, zero}), 64'(held));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          exp_r = q[0];
          chk("model_sum", 64'(sum), 64'(exp_r.sum));
          chk("model_cout", 64'(cout), 64'(exp_r.cout));
          chk("model_ovf", 64'(ovf), 64'(exp_r.ovf));
          chk("model_zero", 64'(zero), 64'(exp_r.zero));
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = '{sum: sum, cout: cout, ovf: ovf, zero: zero};
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, sub, cin));
        n_in++;
      end
    end
  end

  // Present operands until accepted; returns just after the transfer edge
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic sv, input logic cv);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    sub      = sv;
    cin      = cv;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      @(posedge clock);
      #1;
    end
    chk("send_accepted", 64'(done), 64'd1);
  endtask

  // Single transaction into an empty pipe with hand-computed expectations
  task automatic directed(input string name, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic sv, input logic cv,
                          input logic [W-1:0] es, input logic ec,
                          input logic eo, input logic ez);
    int lat;
    out_ready = 1'b1;
    send(av, bv, sv, cv);
    in_valid = 1'b0;
    lat      = 1;
    while (lat < 10) begin
      @(negedge clock);
      if (out_valid) break;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'd2);
    chk({name, "_sum"}, 64'(sum), 64'(es));
    chk({name, "_cout"}, 64'(cout), 64'(ec));
    chk({name, "_ovf"}, 64'(ovf), 64'(eo));
    chk({name, "_zero"}, 64'(zero), 64'(ez));
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors",
             checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    cin       = 1'b0;
    out_ready = 1'b1;

    // Reset with operands being offered
    repeat (2) @(negedge clock);
    in_valid = 1'b1;
    a        = 32'h1234_5678;
    repeat (2) @(negedge clock);
    in_valid = 1'b0;
    #2 reset_n = 1'b1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;

    directed("add_5_3",      32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0,
             32'h0000_0008, 1'b0, 1'b0, 1'b0);
    directed("carry_chain",  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1,
             32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed("wrap_add",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed("sub_ovf",      32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0,
             32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed("sub_borrow",   32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0,
             32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed("sub_cin_ign",  32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1,
             32'h0000_0002, 1'b1, 1'b0, 1'b0);
    directed("add_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed("add_cin",      32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1,
             32'h0000_0009, 1'b0, 1'b0, 1'b0);
    directed("sub_zero",     32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0,
             32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Backpressure: both stages fill, in_ready drops, outputs hold
    base      = n_out;
    out_ready = 1'b0;
    send(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0);
    send(32'h00FF_0000, 32'h0001_0000, 1'b0, 1'b1);
    fork
      begin
        send(32'h1000_0000, 32'h0000_0001, 1'b1, 1'b0);
        send(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (5) begin
          @(negedge clock);
          chk("bp_in_ready_low", 64'(in_ready), 64'd0);
          chk("bp_out_valid", 64'(out_valid), 64'd1);
          chk("bp_sum_first", 64'(sum), 64'h33);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clock);
    #1;
    chk("bp_result_count", 64'(n_out - base), 64'd4);

    // Full rate: one operand accepted every cycle
    base      = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'b1;
      a        = $urandom;
      b        = $urandom;
      sub      = 1'($urandom_range(0, 1));
      cin      = 1'($urandom_range(0, 1));
      if (i % 97 == 0) b = '0;
      if (i % 89 == 0) a = 32'hFFFF_FFFF;
      @(negedge clock);
      chk("full_rate_in_ready", 64'(in_ready), 64'd1);
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("full_rate_count", 64'(n_out - base), 64'd1000);

    // Random valid/ready on both sides
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a         = $urandom;
      b         = $urandom;
      sub       = 1'($urandom_range(0, 1));
      cin       = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("mixed_drained", 64'(q.size()), 64'd0);
    chk("mixed_in_out", 64'(n_out), 64'(n_in));

    // Reset with both stages holding results
    out_ready = 1'b0;
    send(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0);
    send(32'h0000_0300, 32'h0000_0400, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clock);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mid_valid_before", 64'(out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_async_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_async_sum", 64'(sum), 64'd0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clock);
      chk("rst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clock);
    #1;
    directed("after_reset",  32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0,
             32'h0000_0008, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clock);
    #1;
    chk("final_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor, built on 8-bit group generate/propagate logic.
- Generalises the fixed 8-bit group-generate cell to any WIDTH that is a multiple of GROUP.
- Adds a registered inter-group lookahead, add/sub mode, flags and a valid/ready handshake with backpressure.
- Sits between the ALU operand latch and the writeback/flag logic in the datapath.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of GROUP.
- GROUP, 8, bits per lookahead group; NG = WIDTH/GROUP groups.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = A+B+cin; 1 = A-B (B inverted, carry-in forced to 1, cin ignored)
- cin  in  1  carry-in, add mode only
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; in sub mode, 1 means no borrow
- ovf  out  1  signed overflow
- zero  out  1  sum == 0

Behaviour:
- Reset: one clock, asynchronous active-low reset. While reset_n=0, s1_valid=0, out_valid=0, sum=0, cout=0, ovf=0, zero=0. in_ready reads 1 after reset deassertion.
- Handshake:
  - An input transfer occurs when in_valid&&in_ready.
  - An output transfer occurs when out_valid&&out_ready.
  - out_valid and the output data hold stable until transferred.
- Stage 1 (S1 register, loaded on input transfer):
  - b' = sub ? ~b : b; c0 = sub ? 1 : cin.
  - Per group k: group generate Gk = g[top] | p[top]g[top-1] | ... | p[top..base+1]g[base]; group propagate Pk = AND of p over the group.
  - Also register a, b', c0, and the MSB inputs needed for overflow.
- Stage 2 (output register, loaded when S1 advances):
  - Group carry C0 = c0; C(k+1) = Gk | Pk·Ck, computed as a flat lookahead over the registered G/P, not a ripple.
  - Each group's sum = in-group lookahead with carry-in Ck.
  - cout = C(NG).
  - ovf = (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]).
  - zero = ~|sum.
- Pipeline control:
  - S1 advances when s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || S1 advances this cycle. No combinational path from in_valid to in_ready.
  - Latency: 2 cycles from input transfer to out_valid with no stall.
  - Throughput: 1 result/cycle when out_ready is held high.
- Boundary conditions:
  - Simultaneous input transfer, S1 advance and output transfer in one cycle: all three occur and no data is lost.
  - out_ready low with both stages full: in_ready=0. Both stages hold their contents unchanged.
  - Reset mid-operation: all in-flight results are discarded; no out_valid appears after reset until a new input transfer has occurred.
  - Wrap-around is modulo 2^WIDTH, e.g. 0xFFFFFFFF+1 gives sum=0, cout=1, zero=1.
- Elaboration: WIDTH % GROUP != 0 is a fatal error.

Decomposition:
- Shared package cla_pkg holds: DEFAULT_GROUP=8; a function group_gp(g,p) returning {G,P} for a GROUP-bit slice; and localparam NG derivation helpers.
- One natural sub-module: cla_group, the combinational GROUP-bit generate/propagate plus in-group sum given a carry-in. It is instantiated NG times in each stage.

Test Plan:
- Reset and basic add, WIDTH=32, out_ready=1:
  - Stimulus: reset_n low mid-stream. Release, then a=0x0000_0005, b=0x0000_0003, sub=0, cin=0.
  - Required: outputs stay 0 during reset. Exactly 2 cycles later out_valid=1, sum=0x8, cout=0, ovf=0, zero=0.
- Cross-group carry chain:
  - Stimulus: a=0xFFFF_FFFF, b=0x0000_0000, cin=1.
  - Required: sum=0, cout=1, zero=1, ovf=0. This exercises a carry propagating through all 4 groups.
- Subtract and overflow:
  - Stimulus 1: a=0x8000_0000, b=1, sub=1. Required: sum=0x7FFF_FFFF, ovf=1, cout=1.
  - Stimulus 2: a=3, b=5, sub=1. Required: sum=0xFFFF_FFFE, cout=0, ovf=0.
- Backpressure:
  - Stimulus: stream 4 operand sets back-to-back; hold out_ready=0 for 5 cycles, then set it to 1.
  - Required: in_ready drops after 2 transfers; out_valid and sum are stable during the stall; all 4 results emerge in order with no loss or duplication.
- Full throughput, random:
  - Stimulus: 1000 random a/b/sub/cin with out_ready=1.
  - Required: one result per cycle after 2-cycle fill, matching a reference model for sum, cout, ovf and zero.
- Reset mid-flight:
  - Stimulus: assert reset_n=0 while both stages are valid.
  - Required: out_valid falls immediately (asynchronously), and no stale result appears after release.
